// File: rtl/debouncer_multi.sv
// Multi-channel button/switch debouncer: per-channel synchroniser, bounce filter,
// and one-cycle press / release / long-press / auto-repeat strobes.
module debouncer_multi #(
  parameter int                  CHANNELS          = 4,
  parameter logic [CHANNELS-1:0] IDLE_LEVEL        = {CHANNELS{1'b1}},
  parameter int                  SYNC_STAGES       = 2,
  parameter int                  DEBOUNCE_CYCLES   = 1000,
  parameter int                  LONG_PRESS_CYCLES = 50000000,
  parameter int                  REPEAT_CYCLES     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_evt,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_evt,
  output logic                any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] active_s;
  logic                any_press_r;

  // Synchroniser chain, resting at the idle pad level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= IDLE_LEVEL;
    end else begin
      sync_r[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  // Stable level is kept as "pressed" (stable ^ IDLE_LEVEL), so compare in that domain
  assign active_s = sync_r[SYNC_STAGES-1] ^ IDLE_LEVEL;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          pr_r, press_r, rel_r, long_r, rep_r;
    logic          pr_nx_s, press_nx_s, rel_nx_s, long_nx_s, rep_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic [HW-1:0] hold_r, hold_nx_s;
    logic [RW-1:0] rep_cnt_r, rep_cnt_nx_s;

    // Bounce filter and hold/repeat next-state
    always_comb begin
      pr_nx_s      = pr_r;
      cnt_nx_s     = cnt_r;
      hold_nx_s    = hold_r;
      rep_cnt_nx_s = rep_cnt_r;
      long_nx_s    = 1'b0;
      rep_nx_s     = 1'b0;

      if (active_s[i] == pr_r) begin
        cnt_nx_s = '0;
      end else if (cnt_r == CNT_LAST) begin
        pr_nx_s  = active_s[i];
        cnt_nx_s = '0;
      end else begin
        cnt_nx_s = cnt_r + CW'(1);
      end

      press_nx_s = pr_nx_s & ~pr_r;
      rel_nx_s   = ~pr_nx_s & pr_r;

      // Release (or idle) wins over any threshold that lands in the same cycle
      if (!pr_nx_s || !pr_r) begin
        hold_nx_s    = '0;
        rep_cnt_nx_s = '0;
      end else if (hold_r != HOLD_MAX) begin
        hold_nx_s    = hold_r + HW'(1);
        long_nx_s    = (hold_r == HOLD_LAST);
        rep_cnt_nx_s = '0;
      end else if (REPEAT_CYCLES > 0) begin
        if (rep_cnt_r == REP_LAST) begin
          rep_cnt_nx_s = '0;
          rep_nx_s     = 1'b1;
        end else begin
          rep_cnt_nx_s = rep_cnt_r + RW'(1);
        end
      end else begin
        rep_cnt_nx_s = '0;
      end
    end

    // Channel state and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pr_r      <= 1'b0;
        cnt_r     <= '0;
        hold_r    <= '0;
        rep_cnt_r <= '0;
        press_r   <= 1'b0;
        rel_r     <= 1'b0;
        long_r    <= 1'b0;
        rep_r     <= 1'b0;
      end else begin
        pr_r      <= pr_nx_s;
        cnt_r     <= cnt_nx_s;
        hold_r    <= hold_nx_s;
        rep_cnt_r <= rep_cnt_nx_s;
        press_r   <= press_nx_s;
        rel_r     <= rel_nx_s;
        long_r    <= long_nx_s;
        rep_r     <= rep_nx_s;
      end
    end

    assign pressed[i]     = pr_r;
    assign press[i]       = press_r;
    assign release_evt[i] = rel_r;
    assign long_press[i]  = long_r;
    assign repeat_evt[i]  = rep_r;
  end

  // Summary strobe trails the per-channel press strobes by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_press_r <= 1'b0;
    end else begin
      any_press_r <= |press;
    end
  end

  assign any_press = any_press_r;

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed strobe edges.
module tb_debouncer_multi;
  localparam int CH = 4;
  localparam logic [CH-1:0] IDLE = 4'hF;
  localparam int SYNC = 2, DEB = 4, LONG = 20, REP = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0] in = IDLE;
  logic [CH-1:0] pressed, press, release_evt, long_press, repeat_evt;
  logic any_press;

  debouncer_multi #(.CHANNELS(CH), .IDLE_LEVEL(IDLE), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .pressed(pressed), .press(press),
    .release_evt(release_evt), .long_press(long_press), .repeat_evt(repeat_evt),
    .any_press(any_press));

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0, cyc = 0;
  logic [CH-1:0] in_smp = IDLE;
  logic rst_smp = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    in_smp  <= in;
    rst_smp <= rst_n;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural model: pipeline delay, run-length filter, unbounded hold count
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_pressed, m_press, m_rel, m_long, m_rep;
  logic m_any;
  int run [CH];
  int held [CH];

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_back(IDLE);
    m_pressed = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0; m_any = 1'b0;
    for (int c = 0; c < CH; c++) begin run[c] = 0; held[c] = 0; end
  endtask

  task automatic model_step();
    logic [CH-1:0] s;
    logic act;
    s = hist[0];
    m_any = |m_press;
    m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    for (int c = 0; c < CH; c++) begin
      act = s[c] ^ IDLE[c];
      if (act == m_pressed[c]) run[c] = 0;
      else begin
        run[c]++;
        if (run[c] == DEB) begin
          m_pressed[c] = act;
          run[c] = 0;
          held[c] = 0;
          if (act) m_press[c] = 1'b1;
          else m_rel[c] = 1'b1;
        end
      end
      if (m_pressed[c] && !m_press[c]) begin
        held[c]++;
        if (held[c] == LONG) m_long[c] = 1'b1;
        else if (REP > 0 && held[c] > LONG && (held[c] - LONG) % REP == 0) m_rep[c] = 1'b1;
      end
      if (!m_pressed[c]) held[c] = 0;
    end
    hist.push_back(in_smp);
    void'(hist.pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst_n || !rst_smp) model_reset();
    else model_step();
    check("pressed", 32'(pressed), 32'(m_pressed));
    check("press", 32'(press), 32'(m_press));
    check("release", 32'(release_evt), 32'(m_rel));
    check("long_press", 32'(long_press), 32'(m_long));
    check("repeat_evt", 32'(repeat_evt), 32'(m_rep));
    check("any_press", 32'(any_press), 32'(m_any));
  end

  // Event logs (cycle numbers) for the directed checks
  int lg_press[CH][$];
  int lg_rel[CH][$];
  int lg_long[CH][$];
  int lg_rep[CH][$];
  int lg_any[$];

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (press[c] === 1'b1) lg_press[c].push_back(cyc);
      if (release_evt[c] === 1'b1) lg_rel[c].push_back(cyc);
      if (long_press[c] === 1'b1) lg_long[c].push_back(cyc);
      if (repeat_evt[c] === 1'b1) lg_rep[c].push_back(cyc);
    end
    if (any_press === 1'b1) lg_any.push_back(cyc);
  end

  task automatic clear_logs();
    for (int c = 0; c < CH; c++) begin
      lg_press[c].delete(); lg_rel[c].delete(); lg_long[c].delete(); lg_rep[c].delete();
    end
    lg_any.delete();
  endtask

  function automatic int total_events();
    int n;
    n = lg_any.size();
    for (int c = 0; c < CH; c++)
      n += lg_press[c].size() + lg_rel[c].size() + lg_long[c].size() + lg_rep[c].size();
    return n;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    // Reset held with idle pads
    rst_n = 1'b0;
    in = IDLE;
    tick(3);
    check("reset_outputs", 32'({pressed, press, release_evt, long_press, repeat_evt, any_press}), 32'd0);
    rst_n = 1'b1;

    // Power-up idle: nothing for 100 cycles
    clear_logs();
    tick(100);
    check("idle_events", 32'(total_events()), 32'd0);
    check("idle_pressed", 32'(pressed), 32'd0);

    // Clean press ch0, held through long press and repeats
    clear_logs();
    in[0] = 1'b0;
    t0 = cyc;
    tick(44);
    check("t1_press_cnt", 32'(lg_press[0].size()), 32'd1);
    check("t1_press_edge", 32'(lg_press[0][0] - t0), 32'd6);
    check("t1_long_edge", 32'(lg_long[0][0] - t0), 32'd26);
    check("t1_rep_cnt", 32'(lg_rep[0].size()), 32'd3);
    check("t1_rep0_edge", 32'(lg_rep[0][0] - t0), 32'd31);
    check("t1_rep1_edge", 32'(lg_rep[0][1] - t0), 32'd36);
    check("t1_rep2_edge", 32'(lg_rep[0][2] - t0), 32'd41);

    // Release ch0 after 10 held cycles: no long press
    in[0] = 1'b1;
    tick(10);
    clear_logs();
    in[0] = 1'b0;
    t0 = cyc;
    tick(16);
    in[0] = 1'b1;
    tick(10);
    check("t3_press_edge", 32'(lg_press[0][0] - t0), 32'd6);
    check("t3_rel_cnt", 32'(lg_rel[0].size()), 32'd1);
    check("t3_rel_edge", 32'(lg_rel[0][0] - t0), 32'd22);
    check("t3_long_cnt", 32'(lg_long[0].size()), 32'd0);
    check("t3_pressed0", 32'(pressed[0]), 32'd0);

    // Bounce on ch1: 3 low, 1 high, then steady low
    clear_logs();
    in[1] = 1'b0;
    t0 = cyc;
    tick(3);
    in[1] = 1'b1;
    tick(1);
    in[1] = 1'b0;
    tick(12);
    check("t2_press_cnt", 32'(lg_press[1].size()), 32'd1);
    check("t2_press_edge", 32'(lg_press[1][0] - t0), 32'd10);

    // ch2 and ch3 on the same edge
    clear_logs();
    in[2] = 1'b0;
    in[3] = 1'b0;
    t0 = cyc;
    tick(10);
    check("t4_press2_edge", 32'(lg_press[2][0] - t0), 32'd6);
    check("t4_press3_edge", 32'(lg_press[3][0] - t0), 32'd6);
    check("t4_any_cnt", 32'(lg_any.size()), 32'd1);
    check("t4_any_edge", 32'(lg_any[0] - t0), 32'd7);

    // Reset mid-hold on ch0 with the pin still low
    in = IDLE;
    tick(10);
    clear_logs();
    in[0] = 1'b0;
    t0 = cyc;
    tick(21);
    clear_logs();
    rst_n = 1'b0;
    tick(3);
    check("t5_reset_events", 32'(total_events()), 32'd0);
    rst_n = 1'b1;
    t0 = cyc;
    tick(30);
    check("t5_rel_cnt", 32'(lg_rel[0].size()), 32'd0);
    check("t5_press_cnt", 32'(lg_press[0].size()), 32'd1);
    check("t5_press_edge", 32'(lg_press[0][0] - t0), 32'd6);
    check("t5_long_edge", 32'(lg_long[0][0] - t0), 32'd26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
